// File: rtl/fp_divider.sv
// fp_divider: IEEE-754 single-precision divider, z = a / b.
// Restoring shift-subtract, round-to-nearest-even, stb/ack streaming ports.
module fp_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [3:0] {
      get_a,
      get_b,
      unpack,
      special_cases,
      normalise_a,
      normalise_b,
      divide_0,
      divide_1,
      divide_2,
      divide_3,
      normalise_1,
      normalise_2,
      round,
      pack,
      put_z
   } state_t;

   localparam logic signed [9:0] e_inf = 10'sd128;
   localparam logic signed [9:0] e_min = -10'sd127;
   localparam logic signed [9:0] e_den = -10'sd126;
   localparam logic signed [9:0] e_max = 10'sd127;
   localparam logic [31:0] nan_val = 32'hFFC00000;

   state_t state;

   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] z;
   logic [23:0] a_m;
   logic [23:0] b_m;
   logic [23:0] z_m;
   logic signed [9:0] a_e;
   logic signed [9:0] b_e;
   logic signed [9:0] z_e;
   logic a_s;
   logic b_s;
   logic z_s;
   logic guard;
   logic round_bit;
   logic sticky;
   logic [49:0] dividend;
   logic [50:0] divisor;
   // a_m/b_m < 2 after normalisation, so the quotient never needs more
   // than 27 bits; the upper bits of a wider register would stay zero.
   logic [26:0] quotient;
   logic [50:0] remainder;
   logic [5:0] count;

   logic a_zero;
   logic b_zero;
   logic a_nan;
   logic b_nan;
   logic sign;

   assign a_zero = (a_e == e_min) && (a_m == 24'd0);
   assign b_zero = (b_e == e_min) && (b_m == 24'd0);
   assign a_nan  = (a_e == e_inf) && (a_m != 24'd0);
   assign b_nan  = (b_e == e_inf) && (b_m != 24'd0);
   assign sign   = a_s ^ b_s;

   // Control FSM and datapath: one step of the divide per state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= get_a;
         input_a_ack  <= 1'b0;
         input_b_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= 32'd0;
      end else begin
         unique case (state)
            get_a: begin
               input_a_ack <= 1'b1;
               if (input_a_ack && input_a_stb) begin
                  a           <= input_a;
                  input_a_ack <= 1'b0;
                  state       <= get_b;
               end
            end
            get_b: begin
               input_b_ack <= 1'b1;
               if (input_b_ack && input_b_stb) begin
                  b           <= input_b;
                  input_b_ack <= 1'b0;
                  state       <= unpack;
               end
            end
            unpack: begin
               a_m   <= {1'b0, a[22:0]};
               b_m   <= {1'b0, b[22:0]};
               a_e   <= {2'b00, a[30:23]} - 10'd127;
               b_e   <= {2'b00, b[30:23]} - 10'd127;
               a_s   <= a[31];
               b_s   <= b[31];
               state <= special_cases;
            end
            special_cases: begin
               state <= put_z;
               if (a_nan || b_nan) begin
                  z <= nan_val;
               end else if (a_e == e_inf && b_e == e_inf) begin
                  z <= nan_val;
               end else if (a_e == e_inf) begin
                  z <= {sign, 8'hFF, 23'd0};
               end else if (b_e == e_inf) begin
                  z <= {sign, 31'd0};
               end else if (a_zero && b_zero) begin
                  z <= nan_val;
               end else if (b_zero) begin
                  z <= {sign, 8'hFF, 23'd0};
               end else if (a_zero) begin
                  z <= {sign, 31'd0};
               end else begin
                  if (a_e == e_min) a_e <= e_den;
                  else a_m[23] <= 1'b1;
                  if (b_e == e_min) b_e <= e_den;
                  else b_m[23] <= 1'b1;
                  state <= normalise_a;
               end
            end
            normalise_a: begin
               if (a_m[23]) begin
                  state <= normalise_b;
               end else begin
                  a_m <= a_m << 1;
                  a_e <= a_e - 10'sd1;
               end
            end
            normalise_b: begin
               if (b_m[23]) begin
                  state <= divide_0;
               end else begin
                  b_m <= b_m << 1;
                  b_e <= b_e - 10'sd1;
               end
            end
            divide_0: begin
               z_s       <= sign;
               z_e       <= a_e - b_e;
               dividend  <= {a_m, 26'd0};
               divisor   <= {27'd0, b_m};
               quotient  <= 27'd0;
               remainder <= 51'd0;
               count     <= 6'd0;
               state     <= divide_1;
            end
            divide_1: begin
               quotient  <= quotient << 1;
               remainder <= {remainder[49:0], dividend[49]};
               dividend  <= dividend << 1;
               state     <= divide_2;
            end
            divide_2: begin
               if (remainder >= divisor) begin
                  quotient[0] <= 1'b1;
                  remainder   <= remainder - divisor;
               end
               if (count == 6'd49) begin
                  state <= divide_3;
               end else begin
                  count <= count + 6'd1;
                  state <= divide_1;
               end
            end
            divide_3: begin
               z_m       <= quotient[26:3];
               guard     <= quotient[2];
               round_bit <= quotient[1];
               sticky    <= quotient[0] | (remainder != 51'd0);
               state     <= normalise_1;
            end
            normalise_1: begin
               if (!z_m[23]) begin
                  z_e       <= z_e - 10'sd1;
                  z_m       <= {z_m[22:0], guard};
                  guard     <= round_bit;
                  round_bit <= 1'b0;
               end else begin
                  state <= normalise_2;
               end
            end
            normalise_2: begin
               if (z_e < e_den) begin
                  z_e       <= z_e + 10'sd1;
                  z_m       <= z_m >> 1;
                  guard     <= z_m[0];
                  round_bit <= guard;
                  sticky    <= sticky | round_bit;
               end else begin
                  state <= round;
               end
            end
            round: begin
               if (guard && (round_bit | sticky | z_m[0])) begin
                  z_m <= z_m + 24'd1;
                  if (z_m == 24'hFFFFFF) z_e <= z_e + 10'sd1;
               end
               state <= pack;
            end
            pack: begin
               z[31]    <= z_s;
               z[30:23] <= z_e[7:0] + 8'd127;
               z[22:0]  <= z_m[22:0];
               if (z_e == e_den && !z_m[23]) z[30:23] <= 8'd0;
               if (z_e > e_max) begin
                  z[30:23] <= 8'hFF;
                  z[22:0]  <= 23'd0;
               end
               state <= put_z;
            end
            put_z: begin
               output_z_stb <= 1'b1;
               output_z     <= z;
               if (output_z_stb && output_z_ack) begin
                  output_z_stb <= 1'b0;
                  state        <= get_a;
               end
            end
            default: state <= get_a;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors, handshake corners and random operands
// checked against an integer reference model through a scoreboard queue.
module tb_fp_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] input_b;
   logic        input_b_stb;
   logic        input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   always #5 clk = ~clk;

   fp_divider dut (
      .clk(clk),
      .rst(rst),
      .input_a(input_a),
      .input_a_stb(input_a_stb),
      .input_a_ack(input_a_ack),
      .input_b(input_b),
      .input_b_stb(input_b_stb),
      .input_b_ack(input_b_ack),
      .output_z(output_z),
      .output_z_stb(output_z_stb),
      .output_z_ack(output_z_ack)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
   } vec_t;

   localparam int n_vec = 13;
   localparam int limit = 400;

   vec_t        vecs[n_vec];
   logic [31:0] sb_q[$];
   int          checks = 0;
   int          failures = 0;
   bit          abort = 0;
   int          lat;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      abort = 1;
      $display("FAIL %s: no handshake within %0d cycles", name, limit);
   endtask

   function automatic logic [31:0] ref_div(input logic [31:0] a,
                                           input logic [31:0] b);
      logic s;
      logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
      longint unsigned ma, mb, num, q, r, rb, half, mant;
      int ea, eb, e, sh;
      logic [7:0] ef;
      s      = a[31] ^ b[31];
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      if (a_nan || b_nan) return 32'hFFC00000;
      if (a_inf && b_inf) return 32'hFFC00000;
      if (a_inf) return {s, 8'hFF, 23'd0};
      if (b_inf) return {s, 31'd0};
      if (a_zero && b_zero) return 32'hFFC00000;
      if (b_zero) return {s, 8'hFF, 23'd0};
      if (a_zero) return {s, 31'd0};
      ma = 64'(a[22:0]);
      mb = 64'(b[22:0]);
      if (a[30:23] == 8'd0) ea = -126;
      else begin
         ma = ma | (64'd1 << 23);
         ea = int'({24'd0, a[30:23]}) - 127;
      end
      if (b[30:23] == 8'd0) eb = -126;
      else begin
         mb = mb | (64'd1 << 23);
         eb = int'({24'd0, b[30:23]}) - 127;
      end
      while (ma < (64'd1 << 23)) begin
         ma = ma << 1;
         ea--;
      end
      while (mb < (64'd1 << 23)) begin
         mb = mb << 1;
         eb--;
      end
      num = ma << 40;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb;
      sh  = 17;
      if (q < (64'd1 << 40)) begin
         e--;
         sh = 16;
      end
      if (e < -126) begin
         sh = sh + (-126 - e);
         e  = -126;
      end
      if (sh > 60) sh = 60;
      mant = q >> sh;
      rb   = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rb > half || (rb == half && (r != 0 || mant[0]))) mant++;
      if (mant == (64'd1 << 24)) begin
         mant = mant >> 1;
         e++;
      end
      if (e > 127) return {s, 8'hFF, 23'd0};
      if (mant < (64'd1 << 23)) return {s, 8'd0, mant[22:0]};
      ef = 8'(e + 127);
      return {s, ef, mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] m;
      int k;
      k = $urandom_range(0, 19);
      m = 23'($urandom);
      if (k == 0) e = 8'd0;
      else if (k == 1) begin
         e = 8'd0;
         m = 23'd0;
      end else if (k == 2) begin
         e = 8'hFF;
         if ($urandom_range(0, 1) == 1) m = 23'd0;
      end else if (k < 10) e = 8'($urandom_range(100, 154));
      else e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, m};
   endfunction

   task automatic send(input bit sel_b, input logic [31:0] d, input int gap);
      bit ok;
      ok = 0;
      repeat (gap + 1) @(negedge clk);
      if (sel_b) begin
         input_b     = d;
         input_b_stb = 1'b1;
      end else begin
         input_a     = d;
         input_a_stb = 1'b1;
      end
      for (int i = 0; i < limit; i++) begin
         if (sel_b ? input_b_ack : input_a_ack) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         timeout(sel_b ? "b_ack" : "a_ack");
      end else begin
         @(posedge clk);
         #1;
      end
      input_a_stb = 1'b0;
      input_b_stb = 1'b0;
   endtask

   task automatic receive(input int gap);
      logic [31:0] got;
      logic [31:0] exp;
      bit ok;
      bit stable;
      ok     = 0;
      stable = 1;
      lat    = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (output_z_stb) begin
            ok  = 1;
            lat = i;
            break;
         end
      end
      if (!ok) begin
         timeout("z_stb");
         return;
      end
      got = output_z;
      repeat (gap) begin
         @(negedge clk);
         if (!output_z_stb || output_z !== got) stable = 0;
      end
      if (gap > 0) check("z_hold", 32'(stable), 32'd1);
      output_z_ack = 1'b1;
      @(posedge clk);
      #1;
      output_z_ack = 1'b0;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL z_unexpected: got %08h want none", got);
      end else begin
         exp = sb_q.pop_front();
         check("z", got, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z, input int ga, input int gb,
                         input int gz);
      sb_q.push_back(z);
      send(0, a, ga);
      if (abort) return;
      send(1, b, gb);
      if (abort) return;
      receive(gz);
   endtask

   initial begin
      bit b_ok;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
      vecs[2]  = '{32'hC1200000, 32'h40A00000, 32'hC0000000};
      vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000};
      vecs[4]  = '{32'hBF800000, 32'h00000000, 32'hFF800000};
      vecs[5]  = '{32'h00000000, 32'h00000000, 32'hFFC00000};
      vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'hFFC00000};
      vecs[7]  = '{32'h7FC00000, 32'h40000000, 32'hFFC00000};
      vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'h00000000};
      vecs[9]  = '{32'h00800000, 32'h40000000, 32'h00400000};
      vecs[10] = '{32'h00000001, 32'h40000000, 32'h00000000};
      vecs[11] = '{32'h00000001, 32'h3F000000, 32'h00000002};
      vecs[12] = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000};

      rst          = 1'b1;
      input_a      = 32'd0;
      input_b      = 32'd0;
      input_a_stb  = 1'b0;
      input_b_stb  = 1'b0;
      output_z_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_a_ack", 32'(input_a_ack), 32'd0);
      check("rst_b_ack", 32'(input_b_ack), 32'd0);
      check("rst_z_stb", 32'(output_z_stb), 32'd0);
      check("rst_z", output_z, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("a_ack_rise", 32'(input_a_ack), 32'd1);

      for (int i = 0; i < n_vec && !abort; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].z, 0, 0, 0);

      if (!abort) begin
         run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 0);
         check("special_latency", 32'(lat), 32'd3);
      end

      if (!abort) begin
         sb_q.push_back(32'h40400000);
         send(0, 32'h40C00000, 0);
         @(negedge clk);
         b_ok = 1;
         repeat (10) begin
            @(negedge clk);
            if (!input_b_ack || output_z_stb) b_ok = 0;
         end
         check("b_stall", 32'(b_ok), 32'd1);
         send(1, 32'h40000000, 0);
         if (!abort) receive(0);
      end

      if (!abort) run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 20);

      if (!abort) begin
         send(0, 32'h40C00000, 0);
         send(1, 32'h40000000, 0);
         repeat (40) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check("mid_a_ack", 32'(input_a_ack), 32'd0);
         check("mid_b_ack", 32'(input_b_ack), 32'd0);
         check("mid_z_stb", 32'(output_z_stb), 32'd0);
         check("mid_z", output_z, 32'd0);
         rst = 1'b0;
         run_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0);
      end

      for (int i = 0; i < 300 && !abort; i++) begin
         ra = rand_fp();
         rb = rand_fp();
         run_op(ra, rb, ref_div(ra, rb), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
